fht_load_ctrl: RTL and testbench

Input loader for the FHT core. It accepts a stream of signed samples through a valid/ready handshake and sign-extends each sample to the working width. It writes each sample into the four-bank working RAM (`fht_ram_block`) at its bit-reversed position, so the butterfly stages start from a correctly permuted frame. It sits directly upstream of `fht_ram_block` and drives that block's write-side ports (data, write address, write enable).

---
 rtl/fht_pkg.sv | 15 +
 rtl/fht_load_ctrl_if.sv | 36 +++
 rtl/fht_bitrev.sv | 23 ++
 rtl/fht_load_ctrl.sv | 109 ++++++++++
 tb/tb_fht_load_ctrl.sv | 359 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fht_pkg.sv
// Shared definitions for the FHT core: default geometry and loader state encoding.
package fht_pkg;

  localparam int unsigned N_DEF     = 1024;
  localparam int unsigned A_BIT_DEF = 8;
  localparam int unsigned D_BIT_DEF = 17;
  localparam int unsigned D_IN_DEF  = 16;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StLoad  = 2'd1,
    StFlush = 2'd2
  } load_state_e;

endpackage

// File: rtl/fht_load_ctrl_if.sv
// Sample stream in, four-bank RAM write port out.
interface fht_load_ctrl_if
  import fht_pkg::*;
#(
  parameter int unsigned D_IN  = D_IN_DEF,
  parameter int unsigned D_BIT = D_BIT_DEF,
  parameter int unsigned A_BIT = A_BIT_DEF
) ();

  logic             iSTART;
  logic [D_IN-1:0]  iDATA;
  logic             iVALID;
  logic             oREADY;
  logic [D_BIT-1:0] oDATA_0, oDATA_1, oDATA_2, oDATA_3;
  logic [A_BIT-1:0] oADDR_WR_0, oADDR_WR_1, oADDR_WR_2, oADDR_WR_3;
  logic             oWE_0, oWE_1, oWE_2, oWE_3;
  logic             oBUSY;
  logic             oDONE;

  // Upstream sample source / frame controller
  modport master (
    output iSTART, iDATA, iVALID,
    input  oREADY, oDATA_0, oDATA_1, oDATA_2, oDATA_3,
    input  oADDR_WR_0, oADDR_WR_1, oADDR_WR_2, oADDR_WR_3,
    input  oWE_0, oWE_1, oWE_2, oWE_3, oBUSY, oDONE
  );

  // The loader itself
  modport slave (
    input  iSTART, iDATA, iVALID,
    output oREADY, oDATA_0, oDATA_1, oDATA_2, oDATA_3,
    output oADDR_WR_0, oADDR_WR_1, oADDR_WR_2, oADDR_WR_3,
    output oWE_0, oWE_1, oWE_2, oWE_3, oBUSY, oDONE
  );

endinterface

// File: rtl/fht_bitrev.sv
// Bit-reversed sample index split into bank (low 2 bits) and per-bank address.
module fht_bitrev #(
  parameter int unsigned W = 10
) (
  input  logic [W-1:0] i_cnt,
  output logic [1:0]   o_bank,
  output logic [W-3:0] o_addr
);

  logic [W-1:0] w_rev;

  // Mirror the index bit order
  always_comb begin
    w_rev = '0;
    for (int i = 0; i < W; i++) begin
      w_rev[i] = i_cnt[W-1-i];
    end
  end

  assign o_bank = w_rev[1:0];
  assign o_addr = w_rev[W-1:2];

endmodule

// File: rtl/fht_load_ctrl.sv
// FHT input loader: accepts signed samples, sign-extends them and writes each one
// into the four-bank working RAM at its bit-reversed frame position.
module fht_load_ctrl
  import fht_pkg::*;
#(
  parameter int unsigned D_IN  = D_IN_DEF,
  parameter int unsigned D_BIT = D_BIT_DEF,
  parameter int unsigned A_BIT = A_BIT_DEF,
  parameter int unsigned DEPTH = N_DEF / 4
) (
  input logic            iCLK,
  input logic            iRESET,
  fht_load_ctrl_if.slave bus
);

  localparam int unsigned     CW   = A_BIT + 2;
  localparam logic [CW-1:0]   LAST = CW'(4 * DEPTH - 1);

  load_state_e      r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_ready;
  logic             r_busy;
  logic             r_done;
  logic [3:0]       r_we;
  logic [D_BIT-1:0] r_data;
  logic [A_BIT-1:0] r_addr;

  logic             w_accept;
  logic [1:0]       w_bank;
  logic [A_BIT-1:0] w_addr;

  // r_ready is only ever high in LOAD, so it doubles as the state qualifier
  assign w_accept = r_ready & bus.iVALID;

  fht_bitrev #(
    .W (CW)
  ) u_bitrev (
    .i_cnt  (r_cnt),
    .o_bank (w_bank),
    .o_addr (w_addr)
  );

  // Frame FSM, sample counter and registered RAM write port
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_we    <= '0;
      r_data  <= '0;
      r_addr  <= '0;
    end else begin
      r_we   <= '0;
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (bus.iSTART) begin
            r_state <= StLoad;
            r_cnt   <= '0;
            r_ready <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        StLoad: begin
          if (w_accept) begin
            r_cnt  <= r_cnt + CW'(1);
            r_we   <= 4'b0001 << w_bank;
            r_addr <= w_addr;
            r_data <= D_BIT'($signed(bus.iDATA));
            if (r_cnt == LAST) begin
              r_state <= StFlush;
              r_ready <= 1'b0;
            end
          end
        end
        StFlush: begin
          // Last write is on the bus this cycle; report completion next cycle
          r_state <= StIdle;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
        default: begin
          r_state <= StIdle;
          r_ready <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.oREADY     = r_ready;
  assign bus.oBUSY      = r_busy;
  assign bus.oDONE      = r_done;
  assign bus.oWE_0      = r_we[0];
  assign bus.oWE_1      = r_we[1];
  assign bus.oWE_2      = r_we[2];
  assign bus.oWE_3      = r_we[3];
  assign bus.oDATA_0    = r_data;
  assign bus.oDATA_1    = r_data;
  assign bus.oDATA_2    = r_data;
  assign bus.oDATA_3    = r_data;
  assign bus.oADDR_WR_0 = r_addr;
  assign bus.oADDR_WR_1 = r_addr;
  assign bus.oADDR_WR_2 = r_addr;
  assign bus.oADDR_WR_3 = r_addr;

endmodule

// File: tb/tb_fht_load_ctrl.sv
// Directed bench for fht_load_ctrl with a four-bank RAM model fed by the write port.
module tb_fht_load_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fht_load_ctrl_if #(.D_IN(16), .D_BIT(17), .A_BIT(8)) bus ();

  fht_load_ctrl #(
    .D_IN  (16),
    .D_BIT (17),
    .A_BIT (8),
    .DEPTH (256)
  ) dut (
    .iCLK   (clk),
    .iRESET (rst_n),
    .bus    (bus)
  );

  // RAM model
  logic [16:0] mem  [4][256];
  int          wcnt [4][256];
  int          wr_total = 0;
  int          done_cnt = 0;
  bit          seen_first;
  int          first_bank;
  int          first_addr;
  logic [16:0] first_data;

  function automatic logic [16:0] sext(input logic [15:0] v);
    return {v[15], v};
  endfunction

  function automatic logic [15:0] pat(input int n, input logic [15:0] x);
    return 16'(n) ^ x;
  endfunction

  function automatic logic [9:0] rev10(input int n);
    logic [9:0] c, r;
    c = 10'(n);
    for (int i = 0; i < 10; i++) r[i] = c[9-i];
    return r;
  endfunction

  function automatic logic [106:0] out_vec();
    return {bus.oREADY, bus.oBUSY, bus.oDONE, bus.oWE_0, bus.oWE_1, bus.oWE_2, bus.oWE_3,
            bus.oDATA_0, bus.oDATA_1, bus.oDATA_2, bus.oDATA_3,
            bus.oADDR_WR_0, bus.oADDR_WR_1, bus.oADDR_WR_2, bus.oADDR_WR_3};
  endfunction

  // Record whatever the RAM would capture at the coming rising edge
  always @(negedge clk) begin : mon
    logic [3:0] we;
    int b;
    we = {bus.oWE_3, bus.oWE_2, bus.oWE_1, bus.oWE_0};
    if (bus.oDONE === 1'b1) done_cnt++;
    if (we !== 4'b0000) begin
      checks++;
      if (!$onehot(we) || bus.oDATA_1 !== bus.oDATA_0 || bus.oDATA_2 !== bus.oDATA_0 ||
          bus.oDATA_3 !== bus.oDATA_0 || bus.oADDR_WR_1 !== bus.oADDR_WR_0 ||
          bus.oADDR_WR_2 !== bus.oADDR_WR_0 || bus.oADDR_WR_3 !== bus.oADDR_WR_0) begin
        errors++;
        $display("FAIL write_bus: we=%b data=%h/%h/%h/%h addr=%0d/%0d/%0d/%0d, required one-hot we and equal data/addr",
                 we, bus.oDATA_0, bus.oDATA_1, bus.oDATA_2, bus.oDATA_3,
                 bus.oADDR_WR_0, bus.oADDR_WR_1, bus.oADDR_WR_2, bus.oADDR_WR_3);
      end else begin
        b = we[0] ? 0 : we[1] ? 1 : we[2] ? 2 : 3;
        wcnt[b][bus.oADDR_WR_0]++;
        mem[b][bus.oADDR_WR_0] = bus.oDATA_0;
        wr_total++;
        if (!seen_first) begin
          seen_first = 1'b1;
          first_bank = b;
          first_addr = int'(bus.oADDR_WR_0);
          first_data = bus.oDATA_0;
        end
      end
    end
  end

  task automatic clear_model();
    for (int b = 0; b < 4; b++)
      for (int a = 0; a < 256; a++) begin
        wcnt[b][a] = 0;
        mem[b][a]  = 'x;
      end
    seen_first = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.iSTART = 1'b0;
    bus.iVALID = 1'b0;
    bus.iDATA  = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Drive one frame; returns the cycle (1 = first cycle after the start edge) where
  // oDONE was seen, or -1. With chain set, issues the next iSTART in the oDONE cycle.
  task automatic run_frame(input int stall_pct, input logic [15:0] x, input bit do_start,
                           input bit chain, input bit poke, input int abort_after,
                           output int done_cyc, output int sent);
    int n = 0;
    int cyc = 0;
    bit acc;
    done_cyc = -1;
    if (do_start) begin
      @(negedge clk);
      bus.iSTART = 1'b1;
      @(posedge clk);
    end
    while (cyc < 6000) begin
      @(negedge clk);
      cyc++;
      bus.iSTART = 1'b0;
      if (bus.oDONE === 1'b1 && done_cyc < 0) begin
        done_cyc = cyc;
        if (chain) begin
          bus.iSTART = 1'b1;
          bus.iVALID = 1'b0;
          @(posedge clk);
          break;
        end
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
      if (abort_after >= 0 && n == abort_after) break;
      bus.iSTART = poke && (n == 100 || n == 500);
      bus.iVALID = ($urandom_range(99) >= stall_pct);
      bus.iDATA  = pat(n, x);
      acc = bus.oREADY && bus.iVALID;
      @(posedge clk);
      if (acc) n++;
    end
    sent = n;
  endtask

  task automatic verify_frame(input logic [15:0] x, input string nm);
    int bad = 0;
    logic [9:0] r;
    for (int n = 0; n < 1024; n++) begin
      r = rev10(n);
      if (wcnt[r[1:0]][r[9:2]] !== 1 || mem[r[1:0]][r[9:2]] !== sext(pat(n, x))) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL %s: %0d of 1024 locations wrong or not written exactly once, required 0", nm, bad);
    end
  endtask

  task automatic test_reset();
    int w0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_vec() !== '0) begin
      errors++;
      $display("FAIL reset_during: outputs=%h required 0", out_vec());
    end
    rst_n = 1'b1;
    w0 = wr_total;
    bus.iSTART = 1'b0;
    bus.iVALID = 1'b1;
    bus.iDATA  = 16'h1234;
    repeat (16) begin
      @(negedge clk);
      checks++;
      if (out_vec() !== '0) begin
        errors++;
        $display("FAIL reset_idle: outputs=%h required 0", out_vec());
      end
    end
    checks++;
    if (wr_total !== w0) begin
      errors++;
      $display("FAIL reset_no_write: writes=%0d required 0", wr_total - w0);
    end
    bus.iVALID = 1'b0;
  endtask

  task automatic test_sign_ext();
    @(negedge clk);
    bus.iSTART = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.iSTART = 1'b0;
    checks++;
    if (bus.oREADY !== 1'b1 || bus.oBUSY !== 1'b1) begin
      errors++;
      $display("FAIL start_ready: ready=%b busy=%b required 1 1", bus.oREADY, bus.oBUSY);
    end
    bus.iVALID = 1'b1;
    bus.iDATA  = 16'h8000;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.oDATA_0 !== 17'h18000 || bus.oDATA_3 !== 17'h18000 || bus.oWE_0 !== 1'b1 ||
        bus.oADDR_WR_0 !== 8'd0) begin
      errors++;
      $display("FAIL sext_neg: data=%h we0=%b addr=%0d required 18000 1 0",
               bus.oDATA_0, bus.oWE_0, bus.oADDR_WR_0);
    end
    bus.iDATA = 16'h7FFF;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.oDATA_0 !== 17'h07FFF || bus.oDATA_2 !== 17'h07FFF || bus.oWE_0 !== 1'b1 ||
        bus.oADDR_WR_0 !== 8'd128) begin
      errors++;
      $display("FAIL sext_pos: data=%h we0=%b addr=%0d required 07fff 1 128",
               bus.oDATA_0, bus.oWE_0, bus.oADDR_WR_0);
    end
    bus.iVALID = 1'b0;
    bus.iDATA  = 16'h0001;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.oWE_3, bus.oWE_2, bus.oWE_1, bus.oWE_0} !== 4'b0000 ||
        bus.oDATA_0 !== 17'h07FFF || bus.oADDR_WR_0 !== 8'd128) begin
      errors++;
      $display("FAIL stall_hold: we=%b data=%h addr=%0d required 0000 07fff 128",
               {bus.oWE_3, bus.oWE_2, bus.oWE_1, bus.oWE_0}, bus.oDATA_0, bus.oADDR_WR_0);
    end
    do_reset();
  endtask

  task automatic test_ramp();
    int dc, sent, d0;
    int tn[6];
    int tb[6];
    int ta[6];
    tn = '{0, 1, 256, 512, 768, 1023};
    tb = '{0, 0, 2,   1,   3,   3};
    ta = '{0, 128, 0, 0,   0,   255};
    clear_model();
    d0 = done_cnt;
    run_frame(0, 16'h0000, 1'b1, 1'b0, 1'b0, -1, dc, sent);
    checks++;
    if (dc !== 1026) begin
      errors++;
      $display("FAIL ramp_done_cycle: got %0d required 1026", dc);
    end
    checks++;
    if (done_cnt - d0 !== 1) begin
      errors++;
      $display("FAIL ramp_done_pulses: got %0d required 1", done_cnt - d0);
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (wcnt[tb[i]][ta[i]] !== 1 || mem[tb[i]][ta[i]] !== 17'(tn[i])) begin
        errors++;
        $display("FAIL ramp_n%0d: bank %0d addr %0d holds %h (%0d writes) required %h once",
                 tn[i], tb[i], ta[i], mem[tb[i]][ta[i]], wcnt[tb[i]][ta[i]], 17'(tn[i]));
      end
    end
    verify_frame(16'h0000, "ramp_all");
  endtask

  task automatic test_stalls();
    int dc, sent, d0;
    clear_model();
    d0 = done_cnt;
    run_frame(35, 16'hC35A, 1'b1, 1'b0, 1'b1, -1, dc, sent);
    checks++;
    if (dc < 0 || done_cnt - d0 !== 1) begin
      errors++;
      $display("FAIL stall_done: done_cycle=%0d pulses=%0d required one pulse", dc, done_cnt - d0);
    end
    verify_frame(16'hC35A, "stall_frame");
  endtask

  task automatic test_reset_mid();
    int dc, sent, d0;
    clear_model();
    d0 = done_cnt;
    run_frame(0, 16'h0000, 1'b1, 1'b0, 1'b0, 300, dc, sent);
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_vec() !== '0) begin
      errors++;
      $display("FAIL reset_mid_now: outputs=%h required 0", out_vec());
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (out_vec() !== '0 || done_cnt !== d0) begin
      errors++;
      $display("FAIL reset_mid_after: outputs=%h done_pulses=%0d required 0 0",
               out_vec(), done_cnt - d0);
    end
    clear_model();
    run_frame(0, 16'h1111, 1'b1, 1'b0, 1'b0, -1, dc, sent);
    checks++;
    if (first_bank !== 0 || first_addr !== 0 || first_data !== 17'h01111) begin
      errors++;
      $display("FAIL reset_mid_restart: first write bank %0d addr %0d data %h required 0 0 01111",
               first_bank, first_addr, first_data);
    end
    checks++;
    if (dc !== 1026) begin
      errors++;
      $display("FAIL reset_mid_done: got %0d required 1026", dc);
    end
    verify_frame(16'h1111, "reset_mid_frame");
  endtask

  task automatic test_back_to_back();
    int dc, sent, d0;
    clear_model();
    d0 = done_cnt;
    run_frame(0, 16'h0000, 1'b1, 1'b1, 1'b0, -1, dc, sent);
    checks++;
    if (dc !== 1026) begin
      errors++;
      $display("FAIL b2b_first_done: got %0d required 1026", dc);
    end
    verify_frame(16'h0000, "b2b_first_frame");
    clear_model();
    run_frame(30, 16'h5A5A, 1'b0, 1'b0, 1'b0, -1, dc, sent);
    checks++;
    if (first_bank !== 0 || first_addr !== 0 || first_data !== 17'h05A5A) begin
      errors++;
      $display("FAIL b2b_second_first: bank %0d addr %0d data %h required 0 0 05a5a",
               first_bank, first_addr, first_data);
    end
    checks++;
    if (dc < 0 || done_cnt - d0 !== 2) begin
      errors++;
      $display("FAIL b2b_done: done_cycle=%0d pulses=%0d required 2 pulses", dc, done_cnt - d0);
    end
    verify_frame(16'h5A5A, "b2b_second_frame");
  endtask

  initial begin
    rst_n = 1'b0;
    bus.iSTART = 1'b0;
    bus.iVALID = 1'b0;
    bus.iDATA  = '0;
    clear_model();
    do_reset();
    test_reset();
    test_sign_ext();
    test_ramp();
    test_stalls();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
